// File: rtl/la_ioring_pkg.sv
// Shared encodings for the IO ring configuration sequencer: FSM states and
// the meaning of each ring drive bit.
package la_ioring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int RING_SDATA = 0;
  localparam int RING_SHEN  = 1;
  localparam int RING_UPD   = 2;
  localparam int RING_ACT   = 3;
  localparam int RING_MIN_W = 5;

endpackage

// File: rtl/la_ioring_deser.sv
// Serial-to-parallel capture: collects CFGW samples LSB-first while en_i is
// high and presents each completed word with a one-cycle valid pulse.
module la_ioring_deser #(
  parameter int CFGW = 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            sin_i,
  output logic [CFGW-1:0] data_o,
  output logic            valid_o
);

  localparam int BW = $clog2(CFGW);
  localparam logic [BW-1:0] BIT_LAST = BW'(CFGW - 1);

  logic [BW-1:0]   cnt_q, cnt_d;
  logic [CFGW-1:0] sreg_q, sreg_d;
  logic [CFGW-1:0] data_q, data_d;
  logic            valid_q, valid_d;

  // New samples enter at the MSB so the first one ends up in bit 0.
  always_comb begin
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (clr_i) begin
      cnt_d  = '0;
      sreg_d = '0;
    end else if (en_i) begin
      sreg_d = {sin_i, sreg_q[CFGW-1:1]};
      if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        data_d  = sreg_d;
        valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      sreg_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/la_ioring_cfg.sv
// IO ring configuration sequencer: streams host words onto the ring shift
// chain, strobes a ring-wide update and captures the returned chain data.
module la_ioring_cfg
  import la_ioring_pkg::*;
#(
  parameter int RINGW  = 8,
  parameter int NCELLS = 16,
  parameter int CFGW   = 8,
  parameter int UPDW   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CFGW-1:0]  cfg_data,
  output logic [RINGW-1:0] ring_out,
  input  logic [RINGW-1:0] ring_in,
  output logic [CFGW-1:0]  rb_data,
  output logic             rb_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(CFGW);
  localparam int CW = $clog2(NCELLS);
  localparam int UW = $clog2(UPDW + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CFGW - 1);
  localparam logic [CW-1:0] CELL_LAST = CW'(NCELLS - 1);
  localparam logic [UW-1:0] UPD_LAST  = UW'(UPDW);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]   cell_cnt_q, cell_cnt_d;
  logic [UW-1:0]   upd_cnt_q, upd_cnt_d;
  logic [CFGW-1:0] sreg_q, sreg_d;
  logic            loaded_q, loaded_d;
  logic            sdata_q, sdata_d;
  logic            shen_q, shen_d;
  logic            upd_q, upd_d;
  logic            act_q, act_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            ready_s, accept_s, rb_clr_s;
  logic [RINGW-1:0] ring_s;
  logic            unused_ring_s;

  assign unused_ring_s = ^ring_in[RINGW-1:1];

  // The last-bit window lets the next word load with no bubble; abort and
  // reset withdraw ready so a handshake can never be silently dropped.
  assign ready_s   = (state_q == ST_SHIFT) &&
                     (!loaded_q || (bit_cnt_q == BIT_LAST && cell_cnt_q != CELL_LAST));
  assign cfg_ready = ready_s & ~abort & ~reset;
  assign accept_s  = cfg_valid & cfg_ready;
  assign rb_clr_s  = abort | ((state_q == ST_IDLE) & start);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cell_cnt_d = cell_cnt_q;
    upd_cnt_d  = upd_cnt_q;
    sreg_d     = sreg_q;
    loaded_d   = loaded_q;
    sdata_d    = 1'b0;
    shen_d     = 1'b0;
    upd_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          cell_cnt_d = '0;
          loaded_d   = 1'b0;
          sreg_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (loaded_q || accept_s) begin
          // A word accepted into an empty register emits its bit 0 at once.
          shen_d   = 1'b1;
          sdata_d  = loaded_q ? sreg_q[0] : cfg_data[0];
          sreg_d   = loaded_q ? {1'b0, sreg_q[CFGW-1:1]} : {1'b0, cfg_data[CFGW-1:1]};
          loaded_d = 1'b1;
          if (loaded_q && bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (accept_s) begin
              sreg_d = cfg_data;
            end else begin
              loaded_d = 1'b0;
            end
            if (cell_cnt_q == CELL_LAST) begin
              state_d   = ST_UPDATE;
              upd_cnt_d = '0;
            end else begin
              cell_cnt_d = cell_cnt_q + CW'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_UPDATE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (upd_cnt_q == UPD_LAST) begin
          state_d = ST_DONE;
        end else begin
          upd_d     = 1'b1;
          upd_cnt_d = upd_cnt_q + UW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    act_d  = (state_d == ST_SHIFT) || (state_d == ST_UPDATE);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      cell_cnt_q <= '0;
      upd_cnt_q  <= '0;
      sreg_q     <= '0;
      loaded_q   <= 1'b0;
      sdata_q    <= 1'b0;
      shen_q     <= 1'b0;
      upd_q      <= 1'b0;
      act_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cell_cnt_q <= cell_cnt_d;
      upd_cnt_q  <= upd_cnt_d;
      sreg_q     <= sreg_d;
      loaded_q   <= loaded_d;
      sdata_q    <= sdata_d;
      shen_q     <= shen_d;
      upd_q      <= upd_d;
      act_q      <= act_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    ring_s             = '0;
    ring_s[RING_SDATA] = sdata_q;
    ring_s[RING_SHEN]  = shen_q;
    ring_s[RING_UPD]   = upd_q;
    ring_s[RING_ACT]   = act_q;
  end

  assign ring_out = ring_s;
  assign busy     = busy_q;
  assign done     = done_q;

  la_ioring_deser #(
    .CFGW(CFGW)
  ) u_deser (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (rb_clr_s),
    .en_i    (shen_q),
    .sin_i   (ring_in[RING_SDATA]),
    .data_o  (rb_data),
    .valid_o (rb_valid)
  );

endmodule

// File: doc/la_ioring_cfg.md
Name: la_ioring_cfg

Overview:
- Configuration sequencer that sits directly upstream of the IO ring (pads and corner cells sharing the generic `ioring` bus).
- Takes per-cell configuration words from a host over a valid/ready stream.
- Serializes them onto a daisy-chained shift path carried on the ring, then strobes a ring-wide update.
- Captures the old chain contents shifted out of the far end for readback.

Parameters:
- RINGW, 8, width of the io ring bus; must be ≥ 5.
- NCELLS, 16, number of configurable cells in the chain.
- CFGW, 8, configuration bits per cell.
- UPDW, 2, width of the update strobe in clk cycles; must be ≥ 1.

Ports:
- clk  input  1  core clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a frame; ignored unless IDLE.
- abort  input  1  cancels the frame; the update strobe is never issued.
- cfg_valid  input  1  host config word valid.
- cfg_ready  output  1  word accepted on the cycle where cfg_valid and cfg_ready are both high.
- cfg_data  input  CFGW  config word; cell 0 first, LSB shifted first.
- ring_out  output  RINGW  ring drive. [0] sdata, [1] shift_en, [2] update, [3] frame_active, [RINGW-1:4] always 0.
- ring_in  input  RINGW  ring return. [0] chain sdata_out; other bits unused.
- rb_data  output  CFGW  readback word, LSB = first bit returned.
- rb_valid  output  1  one-cycle pulse; rb_data is valid on that cycle.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a frame completes with its update.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and shift registers 0. Reset mid-frame returns to IDLE on the next edge, with no update and no done.
- States: IDLE, SHIFT, UPDATE, DONE.
- IDLE:
  - cfg_ready = 0.
  - start → SHIFT with bit_cnt = 0, cell_cnt = 0, loaded = 0, and ring_out[3] = 1 from the next cycle.
- SHIFT:
  - cfg_ready = !loaded OR (bit_cnt == CFGW-1 AND cell_cnt != NCELLS-1).
  - An accepted word loads sreg and sets loaded.
  - Each cycle with loaded = 1: registered ring_out[0] = sreg[0] and ring_out[1] = 1 on the following cycle. Then sreg >>= 1 and bit_cnt++.
  - A word accepted at cycle T drives its bit 0 on ring_out during T+1.
  - Back-to-back words stream with no bubble. A frame therefore takes exactly NCELLS*CFGW shift cycles when the host never stalls.
  - Host stall (loaded = 0): ring_out[1] = 0 and ring_out[0] = 0; counters hold.
  - At bit_cnt == CFGW-1: bit_cnt wraps to 0 and cell_cnt++. loaded clears unless a new word is accepted the same cycle. If cell_cnt == NCELLS-1 → UPDATE.
- UPDATE: ring_out[2] = 1 for exactly UPDW cycles, with ring_out[1] = 0; then → DONE.
- DONE: done = 1 for one cycle, ring_out[3] drops, → IDLE.
- abort, in SHIFT or UPDATE → IDLE next cycle. ring_out[2:0] forced to 0 immediately from the registered output. A partial update strobe is cut short. done stays 0.
- Simultaneous events:
  - reset overrides abort; abort overrides start and any word acceptance.
  - start while busy is ignored.
- Readback:
  - ring_in[0] is sampled on each cycle where registered ring_out[1] = 1.
  - Samples are assembled LSB-first into rb_sreg with a separate bit counter.
  - rb_valid pulses the cycle after the CFGW-th sample. Exactly NCELLS pulses per completed frame.
  - Readback counters clear on start, abort and reset.
- Width rules: bit_cnt is $clog2(CFGW) wide and cell_cnt is $clog2(NCELLS) wide. Comparisons are against CFGW-1 and NCELLS-1; no modulo wrap beyond them.

Decomposition:
- Package la_ioring_pkg holds:
  - state encoding (IDLE = 0, SHIFT = 1, UPDATE = 2, DONE = 3);
  - ring bit index constants (RING_SDATA = 0, RING_SHEN = 1, RING_UPD = 2, RING_ACT = 3);
  - a minimum-RINGW constant of 5.
- Sub-module la_ioring_deser (CFGW): sample enable plus serial in → rb_data/rb_valid. It has its own counter and a clear input. It is reused later by a scan-readback block.

Test Plan (NCELLS=2, CFGW=4, UPDW=2 unless noted):
- Basic frame: start, then words 4'hA and 4'h3 with cfg_valid held high. ring_out[0] under shift_en must read 0,1,0,1,1,1,0,0 over 8 consecutive cycles. Then update is high for 2 cycles, done pulses once, and busy falls the cycle after done.
- Host stall: cfg_valid drops for 3 cycles after the first word. shift_en is low for those 3 cycles, counters hold, the total shift_en count is still 8, and the update strobe follows the last bit.
- Readback: ring_in[0] returns the pattern 1,1,0,0,1,0,1,0 in step with shift_en. Two rb_valid pulses must carry rb_data 4'h3 then 4'h5.
- Abort: abort asserted on the 5th shift cycle. Next cycle state is IDLE and ring_out[2:0] = 0, update never asserts, done stays 0, and a fresh start works normally.
- Reset mid-UPDATE: reset on the 1st update cycle. All outputs are 0 next cycle, no done pulse, and cfg_ready = 0.
- Simultaneous events: start together with abort in IDLE → remain IDLE. start while busy → ignored, and the frame's shift count is unchanged.
